// File: rtl/mult_unit.sv
// Iterative shift-add multiplier owning the architectural HI/LO registers.
// Optional MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MultStart,
    input  logic             MultSgn,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   w_result;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [CW-1:0]        r_cnt;
    logic                 r_neg;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_last;
    logic                 w_step;

    // Two's complement magnitude; the most negative value maps to its own bit pattern.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            magnitude = v;
        end
    endfunction

    assign w_mag_a  = magnitude(SrcA, MultSgn);
    assign w_mag_b  = magnitude(SrcB, MultSgn);
    assign w_last   = (r_cnt == CNT_LAST);
    assign w_result = r_neg ? (~r_acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : r_acc;

`ifdef MULT_EARLY_EXIT_EN
    assign w_step = (r_mplier != {WIDTH{1'b0}});
`else
    assign w_step = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (MultStart) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!w_step || w_last) begin
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add steps, HI/LO commit and status flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mcand  <= {(2*WIDTH){1'b0}};
            r_acc    <= {(2*WIDTH){1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_neg    <= 1'b0;
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= {WIDTH{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= (r_state == ST_FINISH);
            case (r_state)
                ST_IDLE: begin
                    if (MultStart) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_acc    <= {(2*WIDTH){1'b0}};
                        r_cnt    <= {CW{1'b0}};
                        r_neg    <= MultSgn & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                    end
                end
                ST_RUN: begin
                    if (w_step) begin
                        if (r_mplier[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_FINISH: begin
                    r_hi <= w_result[2*WIDTH-1:WIDTH];
                    r_lo <= w_result[WIDTH-1:0];
                end
                default: begin
                    r_cnt <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign Hi   = r_hi;
    assign Lo   = r_lo;
    assign Busy = r_busy;
    assign Done = r_done;

endmodule

// File: tb/tb_mult_unit.sv
// Directed scoreboard bench for mult_unit: expectations come from a behavioural
// 64-bit multiply and a latency model, queued at launch and popped at Done.
module tb_mult_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         MultStart = 1'b0;
    logic         MultSgn = 1'b0;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;
    logic         Busy;
    logic         Done;

    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] exp_q[$];
    int             lat_q[$];

    always #5 clk = ~clk;

    mult_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .MultStart(MultStart), .MultSgn(MultSgn),
        .SrcA(SrcA), .SrcB(SrcB), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa;
        longint sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'h0, a} * {32'h0, b};
    endfunction

    function automatic int exp_lat(input logic [31:0] b, input logic sgn);
`ifdef MULT_EARLY_EXIT_EN
        logic [31:0] mag;
        int k;
        mag = (sgn && b[31]) ? (32'd0 - b) : b;
        k = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
        return (k + 2 > 33) ? 33 : k + 2;
`else
        return (b[0] | sgn | 1'b1) ? 33 : 33;
`endif
    endfunction

    // Caller sits at a negedge; start is sampled at the next posedge (E0).
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        MultStart = 1'b1; SrcA = a; SrcB = b; MultSgn = sgn;
        exp_q.push_back(model(a, b, sgn));
        lat_q.push_back(exp_lat(b, sgn));
        @(posedge clk); @(negedge clk);
        MultStart = 1'b0; MultSgn = ~sgn; SrcA = 32'hDEAD_BEEF; SrcB = 32'h0BAD_F00D;
        chk("busy_after_start", 64'(Busy), 64'd1);
        chk("done_after_start", 64'(Done), 64'd0);
    endtask

    // Waits for Done; optionally injects a start (2*2) sampled at edge E<inj_at>.
    task automatic wait_done(input int inj_at);
        logic [63:0] expv;
        logic [63:0] old;
        int lat;
        int n;
        logic got;
        expv = exp_q.pop_front();
        lat  = lat_q.pop_front();
        old  = {Hi, Lo};
        n = 1; got = 1'b0;
        while (!got && n <= 40) begin
            if (n == inj_at) begin
                MultStart = 1'b1; SrcA = 32'd2; SrcB = 32'd2; MultSgn = 1'b0;
            end
            @(posedge clk); @(negedge clk);
            MultStart = 1'b0;
            if (Done) begin
                got = 1'b1;
            end else begin
                if (n < lat) begin
                    chk("busy_in_flight", 64'(Busy), 64'd1);
                    chk("hilo_stale", {Hi, Lo}, old);
                end
                n++;
            end
        end
        chk("done_seen", 64'(got), 64'd1);
        if (got) begin
            chk("latency", 64'(n), 64'(lat));
            chk("hilo_result", {Hi, Lo}, expv);
            chk("busy_in_done", 64'(Busy), 64'd0);
        end
    endtask

    task automatic done_drops();
        @(posedge clk); @(negedge clk);
        chk("done_one_cycle", 64'(Done), 64'd0);
    endtask

    initial begin
        int lat;
        int rst_at;
        logic seen;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(Busy), 64'd0);
        chk("reset_done", 64'(Done), 64'd0);
        chk("reset_hilo", {Hi, Lo}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(0);
        chk("umax_value", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
        done_drops();

        // Abort mid-operation: no partial or later commit.
        launch(32'd7, 32'd9, 1'b0);
        lat = lat_q[0];
        rst_at = (lat > 10) ? 10 : lat - 1;
        repeat (rst_at - 1) begin @(posedge clk); @(negedge clk); end
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_done", 64'(Done), 64'd0);
        chk("abort_hilo", {Hi, Lo}, 64'd0);
        void'(exp_q.pop_front());
        void'(lat_q.pop_front());
        seen = 1'b0;
        repeat (40) begin @(posedge clk); @(negedge clk); seen |= Done; end
        chk("abort_no_commit", 64'(seen), 64'd0);
        chk("abort_hilo_later", {Hi, Lo}, 64'd0);

        launch(32'hFFFF_FFFD, 32'd5, 1'b1);
        wait_done(0);
        chk("signed_mixed", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        done_drops();

        launch(32'hFFFF_FFFD, 32'd5, 1'b0);
        wait_done(0);
        chk("unsigned_mixed", {Hi, Lo}, 64'h0000_0004_FFFF_FFF1);
        done_drops();

        launch(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done(0);
        chk("signed_corner", {Hi, Lo}, 64'h4000_0000_0000_0000);
        done_drops();

        // Start while busy is ignored; start in the Done cycle is accepted.
        launch(32'd3, 32'd4, 1'b0);
        wait_done(5);
        chk("busy_start_ignored", {Hi, Lo}, 64'd12);
        launch(32'hFFFF_FFFA, 32'd7, 1'b1);
        wait_done(0);
        chk("back_to_back", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFD6);
        done_drops();
        seen = 1'b0;
        repeat (5) begin @(posedge clk); @(negedge clk); seen |= Busy; end
        chk("no_queued_op", 64'(seen), 64'd0);

        launch(32'h1234_5678, 32'd3, 1'b0);
        wait_done(0);
        chk("early_b3", {Hi, Lo}, 64'h0000_0000_369D_0368);
        done_drops();

        launch(32'h1234_5678, 32'd0, 1'b0);
        wait_done(0);
        chk("early_b0", {Hi, Lo}, 64'd0);
        done_drops();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative shift-add multiplier that services the MultStart/MultSgn requests issued by the instruction decoder for mult/multu.
- Owns the architectural HI/LO registers; their values are read back through the mfhi/mflo writeback paths.
- Sits beside the ALU in the execute stage.
- Raises Busy so the hazard logic can stall the pipeline until the product is committed.

Parameters:
- WIDTH, 32, operand width. Hi and Lo are each WIDTH bits; the internal product is 2*WIDTH bits.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-low reset
- MultStart  input  1  request a multiply; sampled only in IDLE
- MultSgn  input  1  1 = signed (mult), 0 = unsigned (multu); sampled with MultStart
- SrcA  input  WIDTH  multiplicand; sampled with MultStart
- SrcB  input  WIDTH  multiplier; sampled with MultStart
- Hi  output  WIDTH  architectural HI, upper half of the committed product
- Lo  output  WIDTH  architectural LO, lower half of the committed product
- Busy  output  1  high while an operation is in flight
- Done  output  1  one-cycle pulse in the cycle after Hi/Lo commit

Behaviour:
- Reset (reset==0 at a clk edge) forces state=IDLE and clears Hi, Lo, Busy, Done and all internal registers. An in-flight operation is aborted and no partial result is written.
- States:
  - IDLE: if MultStart==1, capture the operands and go to RUN. If MultSgn==1, capture magnitudes |SrcA| and |SrcB| and record neg = SrcA[WIDTH-1] ^ SrcB[WIDTH-1]. Otherwise capture the raw operands with neg=0. Initialise: mcand = zero-extended magnitude of A (2*WIDTH bits), mplier = magnitude of B, acc=0, cnt=0. Magnitude of the most negative value is its unsigned bit pattern, e.g. 0x80000000.
  - RUN: each edge, if mplier[0]==1 then acc += mcand. Then mcand <<= 1, mplier >>= 1, cnt += 1. When cnt reaches WIDTH on this edge, go to FINISH.
  - FINISH: one edge. Hi:Lo <= neg ? -acc : acc (two's complement, 2*WIDTH bits). Done <= 1 and state <= IDLE.
- Busy = (state != IDLE), registered.
- Done clears on the edge after it is set.
- Latency: start sampled at edge E0, WIDTH RUN edges E1..EWIDTH, commit at E(WIDTH+1). That is 33 edges for WIDTH=32.
- Hi/Lo hold their previous values for the whole operation; mfhi/mflo during Busy read stale data, so the hazard unit must stall on Busy.
- MultStart while Busy: ignored, no restart, no queueing.
- MultStart in the Done cycle: accepted, because state is already IDLE. Done still drops on the next edge.
- Arithmetic wraps modulo 2^(2*WIDTH); no overflow flag.
- MultSgn is ignored except when MultStart is sampled in IDLE.

Optional Feature:
- Macro: MULT_EARLY_EXIT_EN.
- Defined: on a RUN edge where mplier==0 (checked before the step), perform no accumulate, shift or count, and go to FINISH. Commit therefore occurs (k+2) edges after E0, where k = index of the highest set bit of |SrcB| plus one, with k=0 for zero. The WIDTH-step bound still applies, so latency never exceeds the default.
- Undefined: fixed latency of WIDTH+1 edges regardless of operand values.
- The result value is identical in both builds.

Test Plan:
- Reset mid-operation: start 7*9 unsigned, pull reset low at E10 -> Busy=0, Done=0, Hi=0, Lo=0 next cycle; no later commit occurs.
- Unsigned max: SrcA=SrcB=0xFFFFFFFF, MultSgn=0 -> Hi=0xFFFFFFFE, Lo=0x00000001; Done pulses exactly at E33 (default build); Busy high E1..E32 cycles.
- Signed mixed: SrcA=0xFFFFFFFD (-3), SrcB=5, MultSgn=1 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. Same operands with MultSgn=0 -> Hi=0x00000004, Lo=0xFFFFFFF1.
- Signed corner: SrcA=SrcB=0x80000000, MultSgn=1 -> Hi=0x40000000, Lo=0x00000000.
- Start while busy: second MultStart with 2*2 at E5 of a 3*4 operation -> ignored; commit gives Lo=12, Hi=0. A back-to-back start asserted in the Done cycle -> accepted, Busy=1 next cycle.
- Early exit (MULT_EARLY_EXIT_EN defined): SrcB=3 -> commit at E4, Lo=3*SrcA. SrcB=0 -> commit at E2, Hi=Lo=0. Undefined build: both commit at E33 with the same values.
